// File: rtl/ack_req_ctrl.sv
// rtl/ack_req_ctrl.sv - per-source ACK request controller with pending count, holdoff and error flags
// One instance per ACK bus source; queues completions and requests the bus once per pending ACK.
module ack_req_ctrl #(
  parameter int PEND_W  = 3,
  parameter int HOLDOFF = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              done_pulse,
  input  logic              ack_ready,
  input  logic              clr_err,
  output logic              req,
  output logic              ack_sent,
  output logic [PEND_W-1:0] pend_count,
  output logic              overflow,
  output logic              timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [3:0]        HOLD_LOAD = 4'(HOLDOFF - 1);
  localparam logic [15:0]       WAIT_LAST = 16'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PEND_W-1:0] r_pend;
  logic [PEND_W-1:0] w_pend_nxt;
  logic [3:0]        r_hold;
  logic [15:0]       r_wait;
  logic              r_req;
  logic              r_overflow;
  logic              r_timeout;
  logic              w_grant;
  logic              w_ovf_set;
  logic              w_tmo_set;

  assign w_ovf_set = done_pulse && (r_pend == PEND_MAX) && !w_grant;
  // Fires once, on the ungranted REQ cycle that brings the wait count up to TIMEOUT.
  assign w_tmo_set = (r_state == S_REQ) && !ack_ready && (r_wait == WAIT_LAST);

  always_comb begin
    w_pend_nxt = r_pend;
    if (done_pulse && !w_grant && (r_pend != PEND_MAX)) begin
      w_pend_nxt = r_pend + PEND_ONE;
    end else if (!done_pulse && w_grant) begin
      w_pend_nxt = r_pend - PEND_ONE;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_pend != '0) || done_pulse) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        w_grant = ack_ready;
        if (ack_ready) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (r_hold == 4'd0) w_state_nxt = (w_pend_nxt != '0) ? S_REQ : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_pend     <= '0;
      r_hold     <= 4'd0;
      r_wait     <= 16'd0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt == S_REQ);
      r_pend  <= w_pend_nxt;
      if (w_grant) begin
        r_hold <= HOLD_LOAD;
      end else if ((r_state == S_HOLD) && (r_hold != 4'd0)) begin
        r_hold <= r_hold - 4'd1;
      end
      // Wait count is only non-zero inside REQ, so entering REQ always starts from 0.
      if ((r_state == S_REQ) && !ack_ready) begin
        if (r_wait != 16'hFFFF) r_wait <= r_wait + 16'd1;
      end else begin
        r_wait <= 16'd0;
      end
      r_overflow <= w_ovf_set || (r_overflow && !clr_err);
      r_timeout  <= w_tmo_set || (r_timeout && !clr_err);
    end
  end

  assign req         = r_req;
  assign ack_sent    = w_grant;
  assign pend_count  = r_pend;
  assign overflow    = r_overflow;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_ack_req_ctrl.sv
// tb/tb_ack_req_ctrl.sv - directed and random checks of ack_req_ctrl against a cycle reference model
module tb_ack_req_ctrl;

  localparam int PEND_W  = 3;
  localparam int HOLDOFF = 2;
  localparam int TIMEOUT = 10;
  localparam int MAXC    = (1 << PEND_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              done_pulse = 1'b0;
  logic              ack_ready = 1'b0;
  logic              clr_err = 1'b0;
  logic              req;
  logic              ack_sent;
  logic [PEND_W-1:0] pend_count;
  logic              overflow;
  logic              timeout_err;

  int errors = 0;
  int checks = 0;

  int m_cnt, m_gap, m_wait, m_req, m_ovf, m_tmo;

  always #5 clk = ~clk;

  ack_req_ctrl #(
    .PEND_W (PEND_W),
    .HOLDOFF(HOLDOFF),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .done_pulse (done_pulse),
    .ack_ready  (ack_ready),
    .clr_err    (clr_err),
    .req        (req),
    .ack_sent   (ack_sent),
    .pend_count (pend_count),
    .overflow   (overflow),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_gap = 0; m_wait = 0; m_req = 0; m_ovf = 0; m_tmo = 0;
  endtask

  // After a grant the line stays low for exactly HOLDOFF cycles, then requests if work is queued.
  task automatic model_update(input int d, input int g, input int c);
    int nc;
    int ovf_set;
    int tmo_set;
    nc      = m_cnt + d - g;
    ovf_set = (d == 1 && m_cnt == MAXC && g == 0) ? 1 : 0;
    if (nc > MAXC) nc = MAXC;
    tmo_set = 0;
    if (m_req != 0 && g == 0) begin
      m_wait++;
      if (m_wait == TIMEOUT) tmo_set = 1;
    end else begin
      m_wait = 0;
    end
    if (g != 0) begin
      m_req = 0;
      m_gap = HOLDOFF;
    end else if (m_req == 0) begin
      if (m_gap <= 1) begin
        m_gap = 0;
        m_req = (nc != 0) ? 1 : 0;
      end else begin
        m_gap--;
      end
    end
    m_cnt = nc;
    m_ovf = (ovf_set != 0 || (m_ovf != 0 && c == 0)) ? 1 : 0;
    m_tmo = (tmo_set != 0 || (m_tmo != 0 && c == 0)) ? 1 : 0;
  endtask

  task automatic check_regs();
    chk("req", 32'(req), 32'(m_req));
    chk("pend_count", 32'(pend_count), 32'(m_cnt));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
  endtask

  task automatic step(input int d, input int a, input int c);
    int g;
    g = (a != 0 && m_req != 0) ? 1 : 0;
    done_pulse = (d != 0);
    ack_ready  = (g != 0);
    clr_err    = (c != 0);
    #1;
    chk("ack_sent", 32'(ack_sent), 32'(g));
    chk("grant_legal", 32'(ack_ready && !req), 32'd0);
    model_update(d, g, c);
    @(posedge clk);
    #1;
    check_regs();
  endtask

  initial begin
    int dp[4] = '{30, 80, 10, 60};
    int ap[4] = '{70, 15, 90, 5};
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_regs();
    rst_n = 1'b1;

    // single ACK with immediate grant
    repeat (4) step(0, 0, 0);
    step(1, 1, 0);
    chk("single_req_hi", 32'(req), 32'd1);
    chk("single_pend1", 32'(pend_count), 32'd1);
    step(0, 1, 0);
    chk("single_req_lo", 32'(req), 32'd0);
    chk("single_pend0", 32'(pend_count), 32'd0);
    repeat (3) step(0, 1, 0);

    // burst of three, always granted
    repeat (3) step(1, 1, 0);
    chk("burst_peak", 32'(pend_count), 32'd2);
    repeat (10) step(0, 1, 0);
    chk("burst_drain", 32'(pend_count), 32'd0);

    // overflow with no grants
    repeat (8) step(1, 0, 0);
    chk("ovf_sat", 32'(pend_count), 32'(MAXC));
    chk("ovf_set", 32'(overflow), 32'd1);
    step(0, 0, 1);
    chk("ovf_clr", 32'(overflow), 32'd0);
    chk("ovf_keep", 32'(pend_count), 32'(MAXC));

    // done and grant together at max
    step(1, 1, 0);
    chk("simul_cnt", 32'(pend_count), 32'(MAXC));
    chk("simul_ovf", 32'(overflow), 32'd0);

    // starvation
    repeat (13) step(0, 0, 0);
    chk("starve_tmo", 32'(timeout_err), 32'd1);
    chk("starve_req", 32'(req), 32'd1);
    step(0, 1, 1);
    chk("starve_tmo_clr", 32'(timeout_err), 32'd0);
    repeat (25) step(0, 1, 0);
    chk("starve_drain", 32'(pend_count), 32'd0);

    // asynchronous reset while requesting
    repeat (4) step(1, 0, 0);
    chk("rst_pre_cnt", 32'(pend_count), 32'd4);
    done_pulse = 1'b0;
    ack_ready  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(req), 32'd0);
    chk("arst_ack", 32'(ack_sent), 32'd0);
    chk("arst_cnt", 32'(pend_count), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_tmo", 32'(timeout_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check_regs();
    repeat (4) step(0, 1, 0);
    chk("post_rst_req", 32'(req), 32'd0);

    // randomized phases
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 150; i++) begin
        step(($urandom_range(99) < dp[p]) ? 1 : 0,
             ($urandom_range(99) < ap[p]) ? 1 : 0,
             ($urandom_range(99) < 3) ? 1 : 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ack_req_ctrl.md
# ack_req_ctrl

Per-source request controller sitting directly upstream of the ACK bus arbiter, with one instance per bus source: MEM, SHA, AES and CTRL.
- Counts completion events from its owning module.
- Drives that source's `req_*` line into the ACK bus.
- Retires one pending ACK per READY grant.
- Inserts a programmable holdoff after each grant so that the fixed-priority bus (lowest ID wins) cannot be monopolised by one source.
- Reports overflow and grant-starvation errors.

## Interface
Parameters:
- `PEND_W`, default 3: width of the pending-ACK counter; maximum pending count is 2^PEND_W−1.
- `HOLDOFF`, default 2: number of cycles `req` stays low after each grant; legal range 1..15.
- `TIMEOUT`, default 255: cycles in REQ without a grant before `timeout_err` sets; legal range 1..65535.

Ports:
- `clk`  in  1  — single clock; all state is on the rising edge.
- `rst_n`  in  1  — reset, asynchronous and active-low.
- `done_pulse`  in  1  — one-cycle pulse from the owning module; each pulse queues one ACK.
- `ack_ready`  in  1  — READY grant from the arbiter (`ack_ready_to_*`); combinational from `req`.
- `clr_err`  in  1  — synchronous clear of `overflow` and `timeout_err`.
- `req`  out  1  — registered request to the ACK bus (`req_*`).
- `ack_sent`  out  1  — one-cycle pulse on each accepted grant.
- `pend_count`  out  PEND_W  — current number of pending ACKs.
- `overflow`  out  1  — sticky; a `done_pulse` was dropped.
- `timeout_err`  out  1  — sticky; the block waited TIMEOUT cycles for a grant.

## Operation
FSM states are IDLE, REQ and HOLD.
- **IDLE:** `req`=0. If `pend_count`≠0, or `done_pulse`=1 this cycle, go to REQ next cycle.
- **REQ:** `req`=1.
  - A grant is accepted when `ack_ready`=1 while in REQ.
  - On a grant: `ack_sent`=1 in the same cycle, `pend_count` decrements, go to HOLD, and the holdoff counter loads HOLDOFF−1.
  - With no grant, stay in REQ.
- **HOLD:** `req`=0. The holdoff counter decrements each cycle.
  - At 0, go to REQ if the next `pend_count` is ≠0, otherwise go to IDLE.
- `ack_ready` is ignored in IDLE and HOLD. The arbiter must never grant when `req`=0; a bench assertion covers this.

Counter rules:
- Net update per cycle is +`done_pulse` − grant_accepted.
- When a done and a grant occur in the same cycle, `pend_count` is unchanged.
- A `done_pulse` while `pend_count`=max and no grant is accepted that cycle:
  - the count holds at max (saturates, no wrap);
  - `overflow` sets the next cycle.
- A `done_pulse` at max in the same cycle as a grant: the count stays at max and no overflow is raised.

Timeout rules:
- The wait counter (16 bits) clears on entry to REQ and on a grant, and increments each REQ cycle without a grant.
- When it reaches TIMEOUT, `timeout_err` sets. The block stays in REQ and keeps requesting; there is no abort.
- The wait counter saturates.

Error clearing:
- `clr_err`=1 clears both sticky bits next cycle.
- If a set condition occurs in the same cycle as `clr_err`, set wins.

Reset:
- Asserting `rst_n` low at any time forces IDLE immediately, asynchronously.
- All outputs and counters go to 0: `req`=0, `ack_sent`=0, `pend_count`=0, `overflow`=0, `timeout_err`=0.
- Pending ACKs are discarded. Reset deassertion is synchronised externally.

## Timing
- Latency from `done_pulse` (cycle N, starting from IDLE with count 0) to `req`=1 is cycle N+1.
- A grant in the same cycle gives the minimum: `ack_sent` at N+1, `pend_count` returns to 0 at N+2.
- `req` is a flop output; `ack_sent` is combinational (state==REQ & `ack_ready`).
- `req` falls on the cycle after the grant.
- Back-to-back ACKs from one source are spaced 1+HOLDOFF cycles apart (default 3).
- During HOLD, lower-priority sources see the bus free and can win arbitration.

## Test plan
- **Single ACK:** reset, then `done_pulse` at cycle 5, arbiter grants immediately.
  - `req` is high at cycle 6 only; `ack_sent` pulses at 6.
  - `pend_count` reads 1 at 6 and 0 at 7; FSM is back in IDLE at 9.
- **Burst:** 3 `done_pulse`s on consecutive cycles, always granted.
  - `ack_sent` occurs at cycles +1, +4, +7 (HOLDOFF=2).
  - `pend_count` peaks at 2, then reaches 0.
- **Overflow:** no grants, 8 `done_pulse`s with PEND_W=3.
  - `pend_count` saturates at 7; `overflow`=1 on the cycle after the 8th pulse.
  - `clr_err` clears `overflow`; `pend_count` stays 7.
- **Simultaneous:** `done_pulse` in the same cycle as a grant while `pend_count`=7.
  - The count stays 7 and `overflow` stays 0.
- **Starvation:** hold `ack_ready`=0 with TIMEOUT=10.
  - `timeout_err` sets after 10 REQ cycles and `req` stays 1.
  - A later grant completes normally.
- **Reset mid-operation:** assert `rst_n`=0 in REQ with `pend_count`=4.
  - All outputs go to 0 immediately, with no clock edge required.
  - After release, no `req` is raised until a new `done_pulse`.
